// File: rtl/oszto_utemezo.sv
// Round-robin scheduler for the shared oszto divider.
// Short-circuits divide-by-zero and guards the wait with a timeout.
module oszto_utemezo #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       k_req,
    input  logic [WIDTH-1:0] k0_a,
    input  logic [WIDTH-1:0] k0_b,
    input  logic [WIDTH-1:0] k1_a,
    input  logic [WIDTH-1:0] k1_b,
    output logic             osz_start,
    output logic [WIDTH-1:0] osz_a,
    output logic [WIDTH-1:0] osz_b,
    input  logic [WIDTH-1:0] osz_hanyados,
    input  logic [WIDTH-1:0] osz_maradek,
    input  logic             osz_ready,
    input  logic             osz_hiba,
    output logic [WIDTH-1:0] eredm_hanyados,
    output logic [WIDTH-1:0] eredm_maradek,
    output logic             eredm_hiba,
    output logic             eredm_idotullepes,
    output logic             eredm_id,
    output logic             eredm_kesz,
    output logic             foglalt
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, INDIT, VAR, KESZ} state_t;

    state_t           state, state_d;
    logic             utolso;
    logic             id;
    logic [CW-1:0]    cnt;
    logic             grant;
    logic             gnt_id;
    logic             done;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] res_q, res_r;
    logic             res_h, res_t;

    // Contention goes to whoever was not served last
    assign gnt_id = (k_req == 2'b11) ? ~utolso : k_req[1];
    assign sel_a  = gnt_id ? k1_a : k0_a;
    assign sel_b  = gnt_id ? k1_b : k0_b;

    assign osz_start  = (state == INDIT);
    assign eredm_kesz = (state == KESZ);
    assign foglalt    = (state != IDLE);

    always_comb begin
        state_d = state;
        grant   = 1'b0;
        done    = 1'b0;
        res_q   = '0;
        res_r   = '0;
        res_h   = 1'b0;
        res_t   = 1'b0;
        unique case (state)
            IDLE: begin
                if (k_req != 2'b00) begin
                    grant = 1'b1;
                    if (sel_b == '0) begin
                        done    = 1'b1;
                        res_r   = sel_a;
                        res_h   = 1'b1;
                        state_d = KESZ;
                    end else begin
                        state_d = INDIT;
                    end
                end
            end
            INDIT: state_d = VAR;
            VAR: begin
                // cnt==0 marks the first wait cycle, where ready may be stale
                if (osz_ready && cnt != '0) begin
                    done    = 1'b1;
                    res_q   = osz_hanyados;
                    res_r   = osz_maradek;
                    res_h   = osz_hiba;
                    state_d = KESZ;
                end else if (cnt == CW'(TIMEOUT)) begin
                    done    = 1'b1;
                    res_h   = 1'b1;
                    res_t   = 1'b1;
                    state_d = KESZ;
                end
            end
            KESZ:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            utolso            <= 1'b1;
            id                <= 1'b0;
            cnt               <= '0;
            osz_a             <= '0;
            osz_b             <= '0;
            eredm_hanyados    <= '0;
            eredm_maradek     <= '0;
            eredm_hiba        <= 1'b0;
            eredm_idotullepes <= 1'b0;
            eredm_id          <= 1'b0;
        end else begin
            state <= state_d;
            if (grant) begin
                osz_a  <= sel_a;
                osz_b  <= sel_b;
                id     <= gnt_id;
                utolso <= gnt_id;
            end
            if (state == INDIT)
                cnt <= '0;
            else if (state == VAR)
                cnt <= cnt + CW'(1);
            if (done) begin
                eredm_hanyados    <= res_q;
                eredm_maradek     <= res_r;
                eredm_hiba        <= res_h;
                eredm_idotullepes <= res_t;
                eredm_id          <= grant ? gnt_id : id;
            end
        end
    end

endmodule

// File: tb/tb_oszto_utemezo.sv
// Directed bench for oszto_utemezo with a behavioural divider model.
module tb_oszto_utemezo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] k_req = 2'b00;
    logic [3:0] k0_a = '0, k0_b = '0, k1_a = '0, k1_b = '0;
    logic       osz_start;
    logic [3:0] osz_a, osz_b;
    logic [3:0] osz_hanyados = '0, osz_maradek = '0;
    logic       osz_ready = 1'b0, osz_hiba = 1'b0;
    logic [3:0] eredm_hanyados, eredm_maradek;
    logic       eredm_hiba, eredm_idotullepes, eredm_id, eredm_kesz, foglalt;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    bit stale_hold = 1'b0;
    bit stale_req = 1'b0;
    int dcnt = 0;
    bit hold = 1'b0;
    int starts = 0;
    int kesz_cnt = 0;
    int s0, ke0;

    oszto_utemezo #(.WIDTH(4), .TIMEOUT(31)) dut (
        .clk(clk), .rst(rst), .k_req(k_req),
        .k0_a(k0_a), .k0_b(k0_b), .k1_a(k1_a), .k1_b(k1_b),
        .osz_start(osz_start), .osz_a(osz_a), .osz_b(osz_b),
        .osz_hanyados(osz_hanyados), .osz_maradek(osz_maradek),
        .osz_ready(osz_ready), .osz_hiba(osz_hiba),
        .eredm_hanyados(eredm_hanyados), .eredm_maradek(eredm_maradek),
        .eredm_hiba(eredm_hiba), .eredm_idotullepes(eredm_idotullepes),
        .eredm_id(eredm_id), .eredm_kesz(eredm_kesz), .foglalt(foglalt)
    );

    always #5 clk = ~clk;

    // Divider: ready lat cycles after start (lat=0 never), ready stays high until next start
    always @(posedge clk) begin
        if (osz_start) begin
            dcnt <= lat;
            hold <= stale_hold;
            if (!stale_hold) osz_ready <= 1'b0;
        end else begin
            if (hold) begin
                hold      <= 1'b0;
                osz_ready <= 1'b0;
            end
            if (stale_req) begin
                osz_ready    <= 1'b1;
                osz_hanyados <= 4'hE;
                osz_maradek  <= 4'hE;
                osz_hiba     <= 1'b1;
            end
            if (dcnt == 1) begin
                osz_ready    <= 1'b1;
                osz_hanyados <= osz_a / osz_b;
                osz_maradek  <= osz_a % osz_b;
                osz_hiba     <= 1'b0;
            end
            if (dcnt != 0) dcnt <= dcnt - 1;
        end
    end

    always @(posedge clk) begin
        if (osz_start) starts <= starts + 1;
        if (eredm_kesz) kesz_cnt <= kesz_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in cycle 1 (just after the grant edge); returns cycle number of eredm_kesz
    task automatic wait_kesz(input string tag, output int cyc);
        cyc = 0;
        for (int n = 1; n <= 60; n++) begin
            if (eredm_kesz) begin
                cyc = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "_kesz"}, 32'(eredm_kesz), 32'd1);
    endtask

    task automatic op(input string tag, input logic id, input logic [3:0] q,
                      input logic [3:0] r, input logic h, input logic t,
                      input int exp_cyc);
        int cyc;
        wait_kesz(tag, cyc);
        chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_id"}, 32'(eredm_id), 32'(id));
        chk({tag, "_q"}, 32'(eredm_hanyados), 32'(q));
        chk({tag, "_r"}, 32'(eredm_maradek), 32'(r));
        chk({tag, "_hiba"}, 32'(eredm_hiba), 32'(h));
        chk({tag, "_tmo"}, 32'(eredm_idotullepes), 32'(t));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", 32'(osz_start), 32'd0);
        chk("rst_a", 32'(osz_a), 32'd0);
        chk("rst_b", 32'(osz_b), 32'd0);
        chk("rst_foglalt", 32'(foglalt), 32'd0);
        chk("rst_kesz", 32'(eredm_kesz), 32'd0);
        chk("rst_hiba", 32'(eredm_hiba), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // single divide 15/5, ready 4 cycles after start
        @(negedge clk);
        k0_a = 4'd15; k0_b = 4'd5; k_req = 2'b01; lat = 4;
        s0 = starts;
        @(posedge clk); #1;
        chk("single_start", 32'(osz_start), 32'd1);
        chk("single_osz_a", 32'(osz_a), 32'd15);
        chk("single_osz_b", 32'(osz_b), 32'd5);
        op("single", 1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 7);
        k_req = 2'b00;
        @(posedge clk); #1;
        chk("single_idle", 32'(foglalt), 32'd0);
        chk("single_starts", 32'(starts - s0), 32'd1);

        // simultaneous requests straight out of reset
        @(negedge clk);
        rst = 1'b0;
        k0_a = 4'd13; k0_b = 4'd4; k1_a = 4'd9; k1_b = 4'd2;
        k_req = 2'b11; lat = 1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        op("sim0", 1'b0, 4'd3, 4'd1, 1'b0, 1'b0, 4);
        k_req = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        op("sim1", 1'b1, 4'd4, 4'd1, 1'b0, 1'b0, 4);
        k_req = 2'b00;
        @(posedge clk); #1;

        // divide by zero from requester 1
        @(negedge clk);
        k1_a = 4'd7; k1_b = 4'd0; k_req = 2'b10;
        s0 = starts;
        @(posedge clk); #1;
        op("dbz", 1'b1, 4'd0, 4'd7, 1'b1, 1'b0, 1);
        k_req = 2'b00;
        @(posedge clk); #1;
        chk("dbz_nostart", 32'(starts - s0), 32'd0);

        // stuck divider, then a normal request
        @(negedge clk);
        k0_a = 4'd10; k0_b = 4'd3; k_req = 2'b01; lat = 0;
        @(posedge clk); #1;
        op("stuck", 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 34);
        k_req = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        k1_a = 4'd9; k1_b = 4'd4; k_req = 2'b10; lat = 2;
        @(posedge clk); #1;
        op("after", 1'b1, 4'd2, 4'd1, 1'b0, 1'b0, 5);
        k_req = 2'b00;
        @(posedge clk); #1;

        // round robin, both requesters hold for three operations each
        @(negedge clk);
        k0_a = 4'd8; k0_b = 4'd3; k1_a = 4'd11; k1_b = 4'd4;
        k_req = 2'b11; lat = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                op("rr_k0", 1'b0, 4'd2, 4'd2, 1'b0, 1'b0, 4);
            else
                op("rr_k1", 1'b1, 4'd2, 4'd3, 1'b0, 1'b0, 4);
            if (i == 4) k_req[0] = 1'b0;
            if (i == 5) k_req[1] = 1'b0;
            @(posedge clk); #1;
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end

        // reset during VAR, then stale ready in the first VAR cycle
        @(negedge clk);
        k0_a = 4'd12; k0_b = 4'd5; k_req = 2'b01; lat = 0;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", 32'(foglalt), 32'd1);
        rst = 1'b0;
        k_req = 2'b00;
        #1;
        ke0 = kesz_cnt;
        chk("mid_osz_a", 32'(osz_a), 32'd0);
        chk("mid_osz_b", 32'(osz_b), 32'd0);
        chk("mid_foglalt", 32'(foglalt), 32'd0);
        chk("mid_start", 32'(osz_start), 32'd0);
        chk("mid_q", 32'(eredm_hanyados), 32'd0);
        chk("mid_r", 32'(eredm_maradek), 32'd0);
        chk("mid_id", 32'(eredm_id), 32'd0);
        chk("mid_kesz", 32'(eredm_kesz), 32'd0);
        stale_req = 1'b1;
        @(posedge clk); #1;
        stale_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        stale_hold = 1'b1; lat = 3;
        k0_a = 4'd14; k0_b = 4'd3; k1_a = 4'd6; k1_b = 4'd4;
        k_req = 2'b11;
        rst = 1'b1;
        chk("mid_no_kesz", 32'(kesz_cnt - ke0), 32'd0);
        @(posedge clk); #1;
        op("post0", 1'b0, 4'd4, 4'd2, 1'b0, 1'b0, 6);
        k_req = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        op("post1", 1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 6);
        k_req = 2'b00;
        @(posedge clk); #1;
        chk("end_idle", 32'(foglalt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
